// File: rtl/uart_io_fifo.sv
// Buffered byte I/O between the core and uart_tx/uart_rx: TX FIFO drained
// by a small FSM into uart_tx, RX FIFO filled on rx_ready rising edges.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   out_valid/data    core byte offer; out_ready = TX FIFO not full
//   in_req            core pops the RX head; in_valid = RX not empty
//   in_data           RX head zero-extended to IN_W, 0 when empty
//   tx_data/tx_start  byte and one-cycle start pulse to uart_tx
//   tx_busy           uart_tx busy
//   rx_data/ready     uart_rx byte and byte-valid (level or pulse)
//   rx_ferr           uart_rx framing error
//   tx_count/rx_count FIFO occupancies
//   rx_overflow       sticky: RX byte dropped, FIFO full
//   rx_frame_err      sticky: RX byte dropped, framing error
//   status_clr        clears both sticky bits (a same-cycle set wins)
//   loopback          only with UART_IO_FIFO_LOOPBACK_EN defined: in IDLE,
//                     move the TX head straight into the RX FIFO
module uart_io_fifo #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int IN_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef UART_IO_FIFO_LOOPBACK_EN
  input  logic                      loopback,
`endif
  input  logic                      out_valid,
  input  logic [7:0]                out_data,
  output logic                      out_ready,
  input  logic                      in_req,
  output logic                      in_valid,
  output logic [IN_W-1:0]           in_data,
  output logic [7:0]                tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  input  logic [7:0]                rx_data,
  input  logic                      rx_ready,
  input  logic                      rx_ferr,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      rx_overflow,
  output logic                      rx_frame_err,
  input  logic                      status_clr
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  localparam logic [TAW:0] TX_FULL = TX_DEPTH[TAW:0];
  localparam logic [RAW:0] RX_FULL = RX_DEPTH[RAW:0];
  localparam logic [TAW:0] TC_ONE  = {{TAW{1'b0}}, 1'b1};
  localparam logic [RAW:0] RC_ONE  = {{RAW{1'b0}}, 1'b1};
  localparam logic [TAW-1:0] TP_ONE = {{(TAW-1){1'b0}}, 1'b1};
  localparam logic [RAW-1:0] RP_ONE = {{(RAW-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WBUSY = 2'd2;
  localparam logic [1:0] S_WDONE = 2'd3;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp;
  logic [TAW-1:0] tx_rp;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp;
  logic [RAW-1:0] rx_rp;
  logic [1:0]     state;
  logic           rx_ready_q;

  logic       lb_sel;
  logic       lb_move;
  logic       tx_empty;
  logic       tx_push;
  logic       tx_pop;
  logic       rx_full;
  logic       rx_edge;
  logic       rx_ev;
  logic       rx_ev_ok;
  logic       rx_push;
  logic       rx_pop;
  logic       ovf_set;
  logic       ferr_set;
  logic [7:0] rx_src;

`ifdef UART_IO_FIFO_LOOPBACK_EN
  assign lb_sel = loopback;
`else
  assign lb_sel = 1'b0;
`endif

  // Full is judged on the registered count only, so a same-cycle
  // FSM pop never makes room for a push.
  assign out_ready = (tx_count != TX_FULL);
  assign tx_empty  = (tx_count == '0);
  assign tx_push   = out_valid && out_ready;

  // In IDLE the head is either handed to uart_tx (needs tx_busy low)
  // or, in loopback, moved into the RX FIFO regardless of tx_busy.
  assign lb_move = (state == S_IDLE) && lb_sel && !tx_empty;
  assign tx_pop  = (state == S_IDLE) && !tx_empty
                && (lb_sel || !tx_busy);

  assign rx_full  = (rx_count == RX_FULL);
  assign in_valid = (rx_count != '0);
  assign in_data  = in_valid ? IN_W'(rx_mem[rx_rp]) : '0;
  assign rx_pop   = in_req && in_valid;

  // A held rx_ready level produces exactly one event.
  assign rx_edge  = rx_ready && !rx_ready_q;
  assign ferr_set = !lb_sel && rx_edge && rx_ferr;
  assign rx_ev    = lb_sel ? lb_move : rx_edge;
  assign rx_ev_ok = rx_ev && !ferr_set;
  assign rx_src   = lb_sel ? tx_mem[tx_rp] : rx_data;
  assign rx_push  = rx_ev_ok && (!rx_full || rx_pop);
  assign ovf_set  = rx_ev_ok && rx_full && !rx_pop;

  assign tx_start = (state == S_START);

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wp] <= out_data;
    end
    if (rx_push) begin
      rx_mem[rx_wp] <= rx_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) begin
        tx_wp <= tx_wp + TP_ONE;
      end
      if (tx_pop) begin
        tx_rp <= tx_rp + TP_ONE;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TC_ONE;
        2'b01:   tx_count <= tx_count - TC_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_count   <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      if (rx_push) begin
        rx_wp <= rx_wp + RP_ONE;
      end
      if (rx_pop) begin
        rx_rp <= rx_rp + RP_ONE;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RC_ONE;
        2'b01:   rx_count <= rx_count - RC_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx_data <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_pop && !lb_sel) begin
            tx_data <= tx_mem[tx_rp];
            state   <= S_START;
          end
        end
        S_START: begin
          state <= S_WBUSY;
        end
        S_WBUSY: begin
          if (tx_busy) begin
            state <= S_WDONE;
          end
        end
        S_WDONE: begin
          if (!tx_busy) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overflow  <= ovf_set  || (rx_overflow  && !status_clr);
      rx_frame_err <= ferr_set || (rx_frame_err && !status_clr);
    end
  end

endmodule

// File: tb/tb_uart_io_fifo.sv
// Scoreboard bench for uart_io_fifo: expected TX/RX bytes are queued at
// stimulus time and checked by monitors on tx_start and on RX pops.
module tb_uart_io_fifo;

  localparam int FRAME = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_valid = 1'b0;
  logic [7:0]  out_data = 8'h00;
  logic        out_ready;
  logic        in_req = 1'b0;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        rx_ferr = 1'b0;
  logic [4:0]  tx_count;
  logic [4:0]  rx_count;
  logic        rx_overflow;
  logic        rx_frame_err;
  logic        status_clr = 1'b0;
`ifdef UART_IO_FIFO_LOOPBACK_EN
  logic        loopback = 1'b0;
`endif

  logic        hold_busy = 1'b0;
  int          ucnt = 0;
  int          vecs = 0;
  int          errs = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  uart_io_fifo dut (
    .clk          (clk),
    .rst          (rst),
`ifdef UART_IO_FIFO_LOOPBACK_EN
    .loopback     (loopback),
`endif
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .in_req       (in_req),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_ferr      (rx_ferr),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .rx_overflow  (rx_overflow),
    .rx_frame_err (rx_frame_err),
    .status_clr   (status_clr)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for FRAME cycles after each start, and not
  // affected by the unit's reset.
  always @(posedge clk) begin
    if (tx_start) ucnt <= FRAME;
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end
  assign tx_busy = (ucnt != 0) || hold_busy;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      chk("tx_start_while_busy", tx_busy, 0);
      if (tx_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL tx_unexpected: got %0h want none", tx_data);
      end else begin
        chk("tx_data", tx_data, tx_q.pop_front());
      end
    end
    if (in_req && in_valid) begin
      if (rx_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL rx_unexpected: got %0h want none", in_data);
      end else begin
        chk("in_data", in_data, {24'h0, rx_q.pop_front()});
      end
    end
  end

  task automatic wait_tx_idle(input int n);
    int  run = 0;
    bit  ok = 0;
    for (int i = 0; i < n; i++) begin
      if (!tx_busy && tx_count == 0 && tx_q.size() == 0) run++;
      else run = 0;
      if (run >= 4) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("tx_drain", ok, 1);
  endtask

  task automatic rx_pulse(input logic [7:0] b, input logic fe);
    rx_data  = b;
    rx_ferr  = fe;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_ferr  = 1'b0;
    tick();
  endtask

  task automatic clr_status();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
  endtask

  task automatic drain_rx(input int n);
    in_req = 1'b1;
    for (int i = 0; i < n && rx_count != 0; i++) tick();
    in_req = 1'b0;
    chk("rx_drain_count", rx_count, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_ready", out_ready, 1);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_in_data", in_data, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_sticky", {rx_overflow, rx_frame_err}, 0);

    // Three back-to-back pushes held off by busy, then drained in order.
    hold_busy = 1'b1;
    out_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_data = 8'h41 + 8'(i);
      tx_q.push_back(out_data);
      tick();
      chk("tx_count_fill3", tx_count, i + 1);
    end
    out_valid = 1'b0;
    hold_busy = 1'b0;
    wait_tx_idle(300);

    // Fill to 16; a 17th offer must be refused.
    hold_busy = 1'b1;
    out_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      out_data = 8'(i * 3);
      tx_q.push_back(out_data);
      tick();
    end
    chk("tx_full_count", tx_count, 16);
    chk("tx_full_ready", out_ready, 0);
    out_data = 8'hEE;
    repeat (3) tick();
    out_valid = 1'b0;
    repeat (2) tick();
    chk("tx_full_hold", tx_count, 16);
    hold_busy = 1'b0;
    wait_tx_idle(1000);

    // Held rx_ready level pushes once.
    rx_data  = 8'h5A;
    rx_ready = 1'b1;
    rx_q.push_back(8'h5A);
    repeat (10) tick();
    rx_ready = 1'b0;
    chk("rx_level_count", rx_count, 1);
    chk("rx_level_valid", in_valid, 1);
    chk("rx_level_data", in_data, 32'h0000005A);
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
    chk("rx_pop_valid", in_valid, 0);
    chk("rx_empty_data", in_data, 0);

    // Overflow, simultaneous pop+push on full, status clear.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) rx_q.push_back(8'h80 + 8'(i));
      rx_pulse(8'h80 + 8'(i), 1'b0);
    end
    chk("rx_full_count", rx_count, 16);
    chk("rx_ovf_set", rx_overflow, 1);
    clr_status();
    chk("rx_ovf_clr", rx_overflow, 0);
    rx_data  = 8'hC0;
    rx_ready = 1'b1;
    in_req   = 1'b1;
    tick();
    rx_ready = 1'b0;
    in_req   = 1'b0;
    rx_q.push_back(8'hC0);
    chk("rx_popush_count", rx_count, 16);
    chk("rx_popush_ovf", rx_overflow, 0);
    tick();
    rx_data    = 8'hD0;
    rx_ready   = 1'b1;
    status_clr = 1'b1;
    tick();
    rx_ready   = 1'b0;
    status_clr = 1'b0;
    chk("rx_set_wins", rx_overflow, 1);
    clr_status();
    chk("rx_ovf_clr2", rx_overflow, 0);
    drain_rx(40);

    // Framing error drops the byte.
    rx_pulse(8'h33, 1'b1);
    chk("ferr_count", rx_count, 0);
    chk("ferr_set", rx_frame_err, 1);
    chk("ferr_no_ovf", rx_overflow, 0);
    clr_status();
    chk("ferr_clr", rx_frame_err, 0);

    // Reset while uart_tx is mid-frame.
    out_valid = 1'b1;
    out_data  = 8'h77;
    tx_q.push_back(8'h77);
    tick();
    out_valid = 1'b0;
    for (int i = 0; i < 20 && ucnt == 0; i++) tick();
    chk("midframe_started", ucnt != 0, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midframe_rst_count", tx_count, 0);
    chk("midframe_rst_ready", out_ready, 1);
    out_valid = 1'b1;
    out_data  = 8'h88;
    tx_q.push_back(8'h88);
    tick();
    out_valid = 1'b0;
    wait_tx_idle(200);

`ifdef UART_IO_FIFO_LOOPBACK_EN
    loopback  = 1'b1;
    tick();
    out_valid = 1'b1;
    out_data  = 8'h10;
    rx_q.push_back(8'h10);
    tick();
    out_data  = 8'h20;
    rx_q.push_back(8'h20);
    tick();
    out_valid = 1'b0;
    repeat (4) tick();
    chk("lb_rx_count", rx_count, 2);
    chk("lb_tx_count", tx_count, 0);
    drain_rx(10);
    loopback = 1'b0;
    tick();
`endif

    chk("tx_q_empty", tx_q.size(), 0);
    chk("rx_q_empty", rx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_io_fifo.md
Name: uart_io_fifo

Overview:
- Buffered byte I/O unit between the multicycle core and the uart_tx/uart_rx instances.
- Replaces the core's blocking out/in states: the core pushes output bytes into a TX FIFO and pops input bytes from an RX FIFO.
- A TX FSM drains the TX FIFO into uart_tx; received bytes are captured into the RX FIFO.
- FIFO depths are parametrised; overflow and framing errors are reported through sticky status bits.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of 2, at least 2.
- RX_DEPTH, 16, RX FIFO entries; power of 2, at least 2.
- IN_W, 32, width of in_data; the byte is zero-extended; at least 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- out_valid  in  1  core offers out_data.
- out_data  in  8  byte to transmit.
- out_ready  out  1  TX FIFO not full.
- in_req  in  1  core pops the RX head.
- in_valid  out  1  RX FIFO not empty.
- in_data  out  IN_W  RX head, zero-extended; 0 when empty.
- tx_data  out  8  byte presented to uart_tx.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_busy  in  1  uart_tx busy.
- rx_data  in  8  uart_rx byte.
- rx_ready  in  1  uart_rx byte-valid (level or pulse).
- rx_ferr  in  1  uart_rx framing error.
- tx_count  out  $clog2(TX_DEPTH)+1  TX occupancy.
- rx_count  out  $clog2(RX_DEPTH)+1  RX occupancy.
- rx_overflow  out  1  sticky: byte dropped because RX FIFO was full.
- rx_frame_err  out  1  sticky: byte dropped because of a framing error.
- status_clr  in  1  clears both sticky bits.

Behaviour:
- Reset, synchronous:
  - Pointers and counts go to 0; TX FSM goes to IDLE.
  - tx_start=0, tx_data=0, sticky bits=0, rx_ready_q=0.
  - out_ready=1, in_valid=0, in_data=0 in the cycle after reset.
- TX push:
  - A push happens when out_valid && out_ready on a clock edge.
  - out_ready is derived from the registered count only, so no push is accepted when full, even if the FSM pops in the same cycle.
- RX pop:
  - A pop happens when in_req && in_valid; in_req while empty is ignored.
  - in_data is show-ahead and combinational from the head entry.
- RX push:
  - Triggered on the rising edge of rx_ready (rx_ready && !rx_ready_q), so a level held for many cycles pushes exactly once.
  - If rx_ferr=1 at that edge: the byte is dropped and rx_frame_err is set.
  - Else if the FIFO is full and no pop occurs that cycle: the byte is dropped and rx_overflow is set.
  - Push and pop in the same cycle on a full FIFO: both happen and the count is unchanged.
  - Push and pop in the same cycle on an empty FIFO: the pop is ignored and the push happens.
- Counts update by +1, -1 or 0 per cycle. Pointers wrap modulo depth; the extra count bit distinguishes full from empty.
- TX FSM:
  - IDLE: if TX not empty and tx_busy=0, latch the head into tx_data, pop, go to START.
  - START: tx_start=1 for exactly one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_busy=0, then go to IDLE.
  - Minimum spacing between tx_start pulses is 4 cycles plus the UART frame time.
  - tx_data stays stable from START until the next IDLE→START transition.
- Status:
  - status_clr clears both sticky bits.
  - If a set event and status_clr occur in the same cycle, the set wins.
- Reset mid-byte: the FSM returns to IDLE. Because IDLE requires tx_busy=0, an in-flight uart_tx frame is never re-triggered.

Optional Feature:
- Macro: UART_IO_FIFO_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, IDLE moves the TX head directly into the RX FIFO: 1 byte/cycle, no tx_start, tx_busy ignored, rx_* inputs ignored. The RX-full overflow rule still applies.
  - Switching loopback takes effect only in IDLE.
- Undefined: the port is absent and behaviour is as above.

Test Plan:
- Reset, then push 0x41,0x42,0x43 back-to-back → tx_count 1,2,3. Three tx_start pulses carry tx_data 0x41, 0x42, 0x43 in order, each only after tx_busy has dropped. tx_count returns to 0.
- Fill TX (16 pushes) while tx_busy is held at 1 → out_ready=0 at count 16. A 17th out_valid is not accepted. Count stays 16 until busy releases.
- rx_ready held high for 10 cycles with rx_data=0x5A → exactly one push. in_valid=1, in_data=0x0000005A. in_req pop → in_valid=0.
- 17 RX pulses with no pops → rx_count=16, rx_overflow=1. On the full FIFO, pop and push together → count stays 16, no new overflow. status_clr → rx_overflow=0.
- Apply rx_ferr=1 at an rx_ready edge → byte not stored, rx_frame_err=1. Assert rst mid-frame while tx_busy=1 → no tx_start until tx_busy=0.
- With UART_IO_FIFO_LOOPBACK_EN and loopback=1: push 0x10,0x20 → both appear on in_data in order, and tx_start is never asserted.
